cyber_with_ddr: RTL and testbench

- Minimal UART echo subsystem for the Tang Primer test platform.
- UART1 receives 8N1 bytes on GPIOB[1] and buffers them in a 16-entry FIFO standing in for the DDR buffer.
- Buffered bytes are re-transmitted on GPIOB[0].
- Status is mirrored on GPIOA; the block is the simulation top instantiated directly under the bench.

---
 rtl/cyber_pkg.sv | 31 +++
 rtl/cyber_byte_fifo.sv | 51 +++++
 rtl/cyber_with_ddr.sv | 212 +++++++++++++++++++++
 tb/tb_cyber_with_ddr.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cyber_pkg.sv
// Shared types and pin/bit maps for the UART echo subsystem.
`timescale 1ns/1ps
package cyber_pkg;

    // RX and TX FSMs walk the same frame phases.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    // GPIOB pin map. Pin 2 is an otherwise unused input used to hold TX off.
    localparam int TX_PIN   = 0;
    localparam int RX_PIN   = 1;
    localparam int HOLD_PIN = 2;

    // GPIOA status map.
    localparam int GA_BYTE_LSB = 0;
    localparam int GA_CNT_LSB  = 8;
    localparam int GA_FERR     = 12;
    localparam int GA_OVF      = 13;
    localparam int GA_TX_BUSY  = 14;
    localparam int GA_RX_BUSY  = 15;

    // FIFO occupancy shown in a 4-bit field; a full 16-deep FIFO reads as 15.
    function automatic logic [3:0] sat_count(input logic [15:0] cnt);
        return (cnt > 16'd15) ? 4'hF : cnt[3:0];
    endfunction

endpackage

// File: rtl/cyber_byte_fifo.sv
// Byte FIFO with first-word fall-through read and occupancy count.
`timescale 1ns/1ps
module cyber_byte_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept then.
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && !do_push;
    assign pop_data = mem[rd_ptr];

    // Storage write; no reset needed on the data array.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/cyber_with_ddr.sv
// UART echo top: RX 8N1 on GPIOB[1] -> byte FIFO -> TX 8N1 on GPIOB[0], status on GPIOA.
`timescale 1ns/1ps
module cyber_with_ddr
    import cyber_pkg::*;
#(
    parameter int BAUD_DIV   = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        io_clk,
    input  logic        io_rst,
    inout  wire  [15:0] io_gpioa,
    inout  wire  [15:0] io_gpiob
);

    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BIT_CNT  = 16'(BAUD_DIV);
    localparam logic [15:0] HALF_CNT = 16'(BAUD_DIV / 2);

    logic [1:0]  rst_pipe;
    logic        rst;
    logic [1:0]  rx_sync;
    logic        rx_bit;
    logic        tx_hold;

    uart_state_t rx_state, rx_state_d;
    logic [15:0] rx_cnt, rx_cnt_d;
    logic [2:0]  rx_idx, rx_idx_d;
    logic [7:0]  rx_shift, rx_shift_d;
    logic        rx_tick, rx_push, rx_ferr;

    uart_state_t tx_state, tx_state_d;
    logic [15:0] tx_cnt, tx_cnt_d;
    logic [2:0]  tx_idx, tx_idx_d;
    logic [7:0]  tx_shift, tx_shift_d;
    logic        tx_tick, tx_pop, tx_can_pop, tx_line;

    logic [7:0]    last_byte;
    logic          ferr_flag, ovf_flag;
    logic [7:0]    fifo_rd_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty, fifo_ovf;
    logic [15:0]   gpioa;

    // Reset asserts immediately and releases on a clock edge.
    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) rst_pipe <= 2'b11;
        else        rst_pipe <= {rst_pipe[0], 1'b0};
    end
    assign rst = rst_pipe[1];

    // Two-flop synchronizer on the RX pin; idles high.
    always_ff @(posedge io_clk or posedge rst) begin
        if (rst) rx_sync <= 2'b11;
        else     rx_sync <= {rx_sync[0], io_gpiob[RX_PIN]};
    end
    assign rx_bit  = rx_sync[1];
    assign tx_hold = io_gpiob[HOLD_PIN];

    // RX state register.
    always_ff @(posedge io_clk or posedge rst) begin
        if (rst) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_idx   <= rx_idx_d;
            rx_shift <= rx_shift_d;
        end
    end

    // RX next state: half-bit to mid start, then one sample per bit period.
    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_idx_d   = rx_idx;
        rx_shift_d = rx_shift;
        rx_push    = 1'b0;
        rx_ferr    = 1'b0;
        rx_tick    = (rx_cnt == 16'd1);
        if (rx_state != ST_IDLE && !rx_tick) rx_cnt_d = rx_cnt - 16'd1;
        case (rx_state)
            ST_IDLE: if (!rx_bit) begin
                rx_state_d = ST_START;
                rx_cnt_d   = HALF_CNT;
            end
            ST_START: if (rx_tick) begin
                rx_state_d = rx_bit ? ST_IDLE : ST_DATA;
                rx_cnt_d   = BIT_CNT;
                rx_idx_d   = '0;
            end
            ST_DATA: if (rx_tick) begin
                rx_shift_d = {rx_bit, rx_shift[7:1]};
                rx_cnt_d   = BIT_CNT;
                rx_idx_d   = rx_idx + 3'd1;
                if (rx_idx == 3'd7) rx_state_d = ST_STOP;
            end
            ST_STOP: if (rx_tick) begin
                rx_push    = rx_bit;
                rx_ferr    = !rx_bit;
                rx_state_d = ST_IDLE;
            end
        endcase
    end

    cyber_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (io_clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (tx_pop),
        .pop_data  (fifo_rd_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (fifo_ovf)
    );

    // Last good byte and sticky error flags; the byte is latched even if the FIFO drops it.
    always_ff @(posedge io_clk or posedge rst) begin
        if (rst) begin
            last_byte <= '0;
            ferr_flag <= 1'b0;
            ovf_flag  <= 1'b0;
        end else begin
            if (rx_push) last_byte <= rx_shift;
            ferr_flag <= ferr_flag | rx_ferr;
            ovf_flag  <= ovf_flag | fifo_ovf;
        end
    end

    // TX state register.
    always_ff @(posedge io_clk or posedge rst) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_idx   <= tx_idx_d;
            tx_shift <= tx_shift_d;
        end
    end

    // TX next state: pop on entry to START, chain frames straight from STOP.
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_idx_d   = tx_idx;
        tx_shift_d = tx_shift;
        tx_pop     = 1'b0;
        tx_can_pop = !fifo_empty && !tx_hold;
        tx_tick    = (tx_cnt == 16'd1);
        if (tx_state != ST_IDLE && !tx_tick) tx_cnt_d = tx_cnt - 16'd1;
        case (tx_state)
            ST_IDLE: if (tx_can_pop) begin
                tx_pop     = 1'b1;
                tx_shift_d = fifo_rd_data;
                tx_cnt_d   = BIT_CNT;
                tx_state_d = ST_START;
            end
            ST_START: if (tx_tick) begin
                tx_cnt_d   = BIT_CNT;
                tx_idx_d   = '0;
                tx_state_d = ST_DATA;
            end
            ST_DATA: if (tx_tick) begin
                tx_shift_d = {1'b0, tx_shift[7:1]};
                tx_cnt_d   = BIT_CNT;
                tx_idx_d   = tx_idx + 3'd1;
                if (tx_idx == 3'd7) tx_state_d = ST_STOP;
            end
            ST_STOP: if (tx_tick) begin
                if (tx_can_pop) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_rd_data;
                    tx_cnt_d   = BIT_CNT;
                    tx_state_d = ST_START;
                end else begin
                    tx_state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Line decoded from state so reset forces it high without waiting for a clock.
    always_comb begin
        tx_line = 1'b1;
        if (tx_state == ST_START)     tx_line = 1'b0;
        else if (tx_state == ST_DATA) tx_line = tx_shift[0];
    end

    // Status word for GPIOA.
    always_comb begin
        gpioa                       = '0;
        gpioa[GA_BYTE_LSB +: 8]     = last_byte;
        gpioa[GA_CNT_LSB +: 4]      = sat_count(16'(fifo_count));
        gpioa[GA_FERR]              = ferr_flag;
        gpioa[GA_OVF]               = ovf_flag;
        gpioa[GA_TX_BUSY]           = (tx_state != ST_IDLE);
        gpioa[GA_RX_BUSY]           = (rx_state != ST_IDLE);
    end

    assign io_gpioa = gpioa;
    // Only the TX pin (bit 0) is driven; the rest of the bank floats.
    assign io_gpiob = {15'bz, tx_line};

endmodule

// File: tb/tb_cyber_with_ddr.sv
// Directed bench: RX stimulus pushes expected echo bytes; a TX-line monitor decodes and compares.
`timescale 1ns/1ps
module tb_cyber_with_ddr;

    localparam int BAUD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_line = 1'b1;
    logic tx_hold = 1'b0;
    wire [15:0] gpioa;
    wire [15:0] gpiob;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    assign gpiob = {13'bz, tx_hold, rx_line, 1'bz};

    cyber_with_ddr #(.BAUD_DIV(BAUD), .FIFO_DEPTH(16)) dut (
        .io_clk   (clk),
        .io_rst   (rst),
        .io_gpioa (gpioa),
        .io_gpiob (gpiob)
    );

    always #18.518 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp_v, input logic [15:0] mask);
        n_vec++;
        if ((act & mask) !== (exp_v & mask)) begin
            n_err++;
            $display("FAIL %s: got %h want %h (mask %h)", name, act, exp_v, mask);
        end
    endtask

    // One 8N1 frame on RX, each bit BAUD cycles, driven at negedges.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_line = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (BAUD) @(negedge clk);
        end
        rx_line = stop;
        repeat (BAUD) @(negedge clk);
        rx_line = 1'b1;
    endtask

    // TX monitor: every bit must hold for exactly BAUD samples; frames cut by reset are dropped.
    initial begin : monitor
        logic [9:0] bits;
        logic [7:0] exp_b;
        bit bad, abort;
        forever begin
            @(negedge clk);
            if (!rst && gpiob[0] === 1'b0) begin
                bad = 0; abort = 0; bits = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < BAUD; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst) abort = 1;
                        if (c == 0) bits[b] = gpiob[0];
                        else if (gpiob[0] !== bits[b]) bad = 1;
                    end
                end
                if (!abort) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL tx_frame: unexpected frame byte %h", bits[8:1]);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (bad || bits[0] !== 1'b0 || bits[9] !== 1'b1 || bits[8:1] !== exp_b) begin
                            n_err++;
                            $display("FAIL tx_frame: got byte %h start %b stop %b width_err %0d want %h",
                                     bits[8:1], bits[0], bits[9], bad, exp_b);
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        int w;
        // Reset state
        repeat (2) @(negedge clk);
        check("reset_gpioa", gpioa, 16'h0000, 16'hFFFF);
        check("reset_tx", {15'd0, gpiob[0]}, 16'h0001, 16'h0001);
        rst = 1'b0;
        repeat (1296) @(negedge clk);

        // Single byte 0xAA echoed
        exp_q.push_back(8'hAA);
        send_frame(8'hAA, 1'b1);
        repeat (8) @(negedge clk);
        check("aa_status", gpioa, 16'h40AA, 16'hFFFF);
        repeat (60) @(negedge clk);
        check("aa_idle", gpioa, 16'h00AA, 16'hFFFF);

        // Back-to-back 0x00, 0xFF
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (8) @(negedge clk);
        check("b2b_byte", gpioa, 16'h00FF, 16'h10FF);
        repeat (100) @(negedge clk);
        check("b2b_idle", gpioa, 16'h00FF, 16'hFFFF);

        // Framing error: byte discarded, flag sticks, no echo
        send_frame(8'h55, 1'b0);
        repeat (8) @(negedge clk);
        check("ferr", gpioa, 16'h10FF, 16'hFFFF);

        // One-cycle low glitch
        rx_line = 1'b0;
        @(negedge clk);
        rx_line = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_rx_busy", gpioa, 16'h8000, 16'h8000);
        repeat (10) @(negedge clk);
        check("glitch_idle", gpioa, 16'h10FF, 16'hFFFF);

        // Overflow with TX held: 17 bytes, 16 kept
        tx_hold = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(8'h10 + i));
            send_frame(8'(8'h10 + i), 1'b1);
            if (i == 15) begin
                repeat (8) @(negedge clk);
                check("full_sat", gpioa, 16'h1F1F, 16'hFFFF);
            end
        end
        repeat (8) @(negedge clk);
        check("overflow", gpioa, 16'h3F20, 16'hFFFF);
        tx_hold = 1'b0;
        repeat (700) @(negedge clk);
        check("ovf_drained", gpioa, 16'h3020, 16'hFFFF);

        // Reset in the middle of a TX frame
        tx_hold = 1'b1;
        send_frame(8'hC3, 1'b1);
        send_frame(8'h3C, 1'b1);
        repeat (8) @(negedge clk);
        check("pre_rst_count", gpioa, 16'h323C, 16'hFFFF);
        tx_hold = 1'b0;
        w = 0;
        while (gpiob[0] !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("tx_start_seen", {15'd0, gpiob[0]}, 16'h0000, 16'h0001);
        repeat (10) @(negedge clk);
        #5 rst = 1'b1;
        #1;
        check("rst_tx_high", {15'd0, gpiob[0]}, 16'h0001, 16'h0001);
        check("rst_gpioa", gpioa, 16'h0000, 16'hFFFF);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("post_rst_gpioa", gpioa, 16'h0000, 16'hFFFF);
        check("post_rst_tx", {15'd0, gpiob[0]}, 16'h0001, 16'h0001);

        // Every expected echo must have been seen
        check("echo_drain", 16'(exp_q.size()), 16'h0000, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
